// File: rtl/rgb_timing_gen.sv
// rgb_timing_gen -- raster timing generator for a parallel RGB panel.
//
// Generates hsync/vsync/data-enable and active-pixel coordinates from a pair
// of free-running line/frame counters. A run request (enable) starts frames at
// (0,0); dropping it lets the current frame finish before the generator parks.
//
// Ports:
//   pixelClk    pixel clock, single clock domain
//   reset       synchronous, active-high reset
//   enable      run request, level-sensitive
//   hs, vs      horizontal / vertical sync, active level set by HS_POL / VS_POL
//   de          data enable, high during active pixels
//   pixelX/Y    active column / row, zero outside the active area
//   lineStart   one-cycle pulse at the first cycle of each line
//   frameStart  one-cycle pulse at the first cycle of each frame
//   stopped     high while the generator is idle
//
// All outputs are registered and lag the counters by exactly one cycle.

module rgb_timing_gen #(
    parameter int   HSYNC_COUNT   = 128,
    parameter int   BACK_PORCH_H  = 128,
    parameter int   PIXELS_H      = 800,
    parameter int   FRONT_PORCH_H = 32,
    parameter int   VSYNC_COUNT   = 4,
    parameter int   BACK_PORCH_V  = 14,
    parameter int   PIXELS_V      = 600,
    parameter int   FRONT_PORCH_V = 1,
    parameter logic HS_POL        = 1'b0,
    parameter logic VS_POL        = 1'b0,
    parameter int   COORD_W       = 10,
    parameter int   CNT_W         = 12
) (
    input  logic               pixelClk,
    input  logic               reset,
    input  logic               enable,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COORD_W-1:0] pixelX,
    output logic [COORD_W-1:0] pixelY,
    output logic               lineStart,
    output logic               frameStart,
    output logic               stopped
);

    localparam int H_TOTAL = HSYNC_COUNT + BACK_PORCH_H + PIXELS_H + FRONT_PORCH_H;
    localparam int V_TOTAL = VSYNC_COUNT + BACK_PORCH_V + PIXELS_V + FRONT_PORCH_V;
    localparam int HA0_I   = HSYNC_COUNT + BACK_PORCH_H;
    localparam int VA0_I   = VSYNC_COUNT + BACK_PORCH_V;

    if (H_TOTAL >= (2 ** CNT_W)) begin : g_bad_htotal
        $error("rgb_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL >= (2 ** CNT_W)) begin : g_bad_vtotal
        $error("rgb_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (PIXELS_H >= (2 ** COORD_W)) begin : g_bad_pixh
        $error("rgb_timing_gen: PIXELS_H does not fit in COORD_W bits");
    end
    if (PIXELS_V >= (2 ** COORD_W)) begin : g_bad_pixv
        $error("rgb_timing_gen: PIXELS_V does not fit in COORD_W bits");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC = CNT_W'(HSYNC_COUNT);
    localparam logic [CNT_W-1:0] V_SYNC = CNT_W'(VSYNC_COUNT);
    localparam logic [CNT_W-1:0] HA0    = CNT_W'(HA0_I);
    localparam logic [CNT_W-1:0] HA1    = CNT_W'(HA0_I + PIXELS_H);
    localparam logic [CNT_W-1:0] VA0    = CNT_W'(VA0_I);
    localparam logic [CNT_W-1:0] VA1    = CNT_W'(VA0_I + PIXELS_V);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] hCnt;
    logic [CNT_W-1:0] vCnt;
    logic             frameLast;
    logic             activeNext;

    assign frameLast  = (hCnt == H_LAST) && (vCnt == V_LAST);
    assign activeNext = (hCnt >= HA0) && (hCnt < HA1) && (vCnt >= VA0) && (vCnt < VA1);

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // DRAIN is RUN with the request withdrawn; the frame only ends (and the
    // request is only honoured) on the frame's final cycle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    stateNext = frameLast ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    stateNext = RUN;
                end else if (frameLast) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Leaving RUN/DRAIN only happens on the frame's last cycle, where the
    // wrap already returns both counters to zero, so IDLE just holds them.
    always_ff @(posedge pixelClk) begin
        if (reset || (state == IDLE)) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end else begin
            hCnt <= hCnt + 1'b1;
        end
    end

    always_ff @(posedge pixelClk) begin
        if (reset || (state == IDLE)) begin
            hs         <= ~HS_POL;
            vs         <= ~VS_POL;
            de         <= 1'b0;
            pixelX     <= '0;
            pixelY     <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            stopped    <= 1'b1;
        end else begin
            hs         <= (hCnt < H_SYNC) ? HS_POL : ~HS_POL;
            vs         <= (vCnt < V_SYNC) ? VS_POL : ~VS_POL;
            de         <= activeNext;
            pixelX     <= activeNext ? COORD_W'(hCnt - HA0) : '0;
            pixelY     <= activeNext ? COORD_W'(vCnt - VA0) : '0;
            lineStart  <= (hCnt == '0);
            frameStart <= (hCnt == '0) && (vCnt == '0);
            stopped    <= 1'b0;
        end
    end

endmodule

// File: doc/rgb_timing_gen.md
RGB_TIMING_GEN -- requirements
Module: rgb_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  HSYNC_COUNT, 128, hsync width in pixel clocks
  BACK_PORCH_H, 128, horizontal back porch clocks
  PIXELS_H, 800, active pixels per line
  FRONT_PORCH_H, 32, horizontal front porch clocks
  VSYNC_COUNT, 4, vsync width in lines
  BACK_PORCH_V, 14, vertical back porch lines
  PIXELS_V, 600, active lines per frame
  FRONT_PORCH_V, 1, vertical front porch lines
  HS_POL, 0, active level of hs (0 = active-low)
  VS_POL, 0, active level of vs (0 = active-low)
  COORD_W, 10, width of pixelX/pixelY
  CNT_W, 12, width of internal hCnt/vCnt counters
REQ-002 Ports (name, direction, width, meaning):
  pixelClk  in  1  pixel clock; single clock domain
  reset  in  1  synchronous, active-high reset
  enable  in  1  run request, level-sensitive
  hs  out  1  horizontal sync, polarity per HS_POL
  vs  out  1  vertical sync, polarity per VS_POL
  de  out  1  data enable, high during active pixels
  pixelX  out  COORD_W  active column, 0..PIXELS_H-1
  pixelY  out  COORD_W  active row, 0..PIXELS_V-1
  lineStart  out  1  one-cycle pulse at hCnt==0
  frameStart  out  1  one-cycle pulse at hCnt==0 && vCnt==0
  stopped  out  1  high while in IDLE
REQ-003 One clock domain (pixelClk); reset synchronous, active-high; all outputs registered.

Function
REQ-004 H_TOTAL = HSYNC_COUNT+BACK_PORCH_H+PIXELS_H+FRONT_PORCH_H; V_TOTAL likewise from the vertical parameters; both SHALL fit in CNT_W bits; PIXELS_H, PIXELS_V SHALL fit in COORD_W bits; elaboration SHALL fail otherwise.
REQ-005 Line layout in hCnt: sync [0,HSYNC_COUNT), back porch, active [HA0,HA0+PIXELS_H) with HA0=HSYNC_COUNT+BACK_PORCH_H, then front porch; vCnt layout identical using the V parameters, VA0=VSYNC_COUNT+BACK_PORCH_V.
REQ-006 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable==1; RUN->DRAIN when enable==0; DRAIN->RUN when enable==1; RUN or DRAIN->IDLE only on the last cycle of a frame (hCnt==H_TOTAL-1 && vCnt==V_TOTAL-1) while enable==0.
REQ-007 In IDLE: hCnt=vCnt=0, held; in RUN/DRAIN hCnt increments each cycle, wraps at H_TOTAL-1 to 0 and increments vCnt; vCnt wraps at V_TOTAL-1 to 0.
REQ-008 First RUN cycle has hCnt=vCnt=0; frames always start at (0,0) and are never truncated.
REQ-009 Outputs reflect counter state with exactly 1 cycle latency, all mutually aligned: hs active iff hCnt<HSYNC_COUNT; vs active iff vCnt<VSYNC_COUNT; de iff hCnt and vCnt both in active ranges.
REQ-010 pixelX = hCnt-HA0 and pixelY = vCnt-VA0 when de; both 0 otherwise.
REQ-011 lineStart/frameStart per REQ-002, same 1-cycle latency; frameStart implies lineStart.
REQ-012 Cycle after entering IDLE: hs=!HS_POL, vs=!VS_POL, de=0, pixelX=pixelY=0, pulses 0, stopped=1; stopped=0 in RUN and DRAIN, registered from state.
REQ-013 enable toggling within a frame SHALL not disturb timing; only the value at the frame's last cycle decides continuation.

Reset
REQ-014 reset dominates enable; next cycle: state IDLE, hCnt=vCnt=0, outputs per REQ-012.
REQ-015 reset mid-frame SHALL abort immediately; with enable high on release, the next frame starts at (0,0) one cycle later.

Verification (params HSYNC=2,HBP=2,PIXELS_H=4,HFP=2 -> H_TOTAL=10; VSYNC=1,VBP=1,PIXELS_V=3,VFP=1 -> V_TOTAL=6; COORD_W=4)
REQ-016 Reset then enable=1 -> frameStart 1 cycle after RUN entry; period 60 cycles; lineStart every 10; hs active 2 cycles/line; vs active first 10 cycles.
REQ-017 Active region -> de high 4 cycles/line on lines 2..4 only (12 per frame); pixelX 0,1,2,3; pixelY 0,1,2.
REQ-018 enable dropped at cycle 25 of a frame -> frame completes (60 cycles total), stopped=1 thereafter, hs/vs inactive, de=0.
REQ-019 enable low at cycle 20, high again at cycle 40 -> no gap, next frameStart exactly 60 cycles after previous.
REQ-020 reset pulsed at cycle 33 with enable high -> stopped=1 next cycle; frameStart 2 cycles after reset deassertion; HS_POL=1/VS_POL=1 run -> sync levels inverted, all else identical.
